verinject_injection_scheduler: RTL and testbench

// - Time-ordered fault-injection sequencer. Drives the verinject__injector_state bus from a queue of
//   (cycle, bit) entries and produces the matching cycle_number consumed by the simulation monitor.
// - Sits at top of sim harness: testbench pushes schedule entries; this block emits one-cycle injections.

---
 rtl/verinject_pkg.sv | 16 +
 rtl/verinject_sched_fifo.sv | 51 +++++
 rtl/verinject_injection_scheduler.sv | 95 +++++++++
 tb/tb_verinject_injection_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verinject_pkg.sv
// Shared types and constants for the verinject fault-injection scheduler.
package verinject_pkg;
  localparam int CYCLE_W = 48;
  localparam logic [31:0] INJ_IDLE  = 32'hFFFF_FFFF;
  localparam logic [31:0] INJ_RESET = 32'hFFFF_FFFE;

  typedef struct packed {
    logic [47:0] cycle;
    logic [31:0] bit_idx;
  } inj_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_ARMED
  } sched_state_t;
endpackage

// File: rtl/verinject_sched_fifo.sv
// Synchronous FIFO of schedule entries with occupancy-based full/empty flags.
module verinject_sched_fifo
  import verinject_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  inj_entry_t wr_data,
  output inj_entry_t rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  inj_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head of queue is presented combinationally so the scheduler can load it on the pop edge.
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/verinject_injection_scheduler.sv
// Time-ordered fault-injection sequencer: fires queued (cycle, bit) entries as
// one-cycle values on the injector state bus, alongside a free-running cycle counter.
module verinject_injection_scheduler
  import verinject_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               sched_valid,
  output logic               sched_ready,
  input  logic [47:0]        sched_cycle,
  input  logic [31:0]        sched_bit,
  output logic [47:0]        cycle_number,
  output logic [31:0]        verinject__injector_state,
  output logic [CNT_W-1:0]   inject_count,
  output logic               late_pulse,
  output logic               order_err,
  output logic               busy
);
  sched_state_t state;
  sched_state_t state_next;
  inj_entry_t   head;
  inj_entry_t   fifo_rd;
  inj_entry_t   fifo_wr;
  logic [47:0]  last_cycle;
  logic         fifo_full;
  logic         fifo_empty;
  logic         accept;
  logic         bad_entry;
  logic         push;
  logic         pop;
  logic         fire;

  assign sched_ready = !fifo_full;
  assign accept      = sched_valid && sched_ready;
  // Out-of-order targets and the idle code are consumed but never queued.
  assign bad_entry   = (sched_cycle < last_cycle) || (sched_bit == INJ_IDLE);
  assign push        = accept && !bad_entry;
  assign fifo_wr     = '{cycle: sched_cycle, bit_idx: sched_bit};

  assign fire = (state == ST_ARMED) && enable && (head.cycle <= cycle_number);
  assign pop  = !fifo_empty && ((state == ST_IDLE) || fire);
  assign busy = (state == ST_ARMED) || !fifo_empty;

  verinject_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_next                = state;
    verinject__injector_state = INJ_IDLE;
    late_pulse                = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (fire) begin
          verinject__injector_state = head.bit_idx;
          late_pulse                = (head.cycle < cycle_number);
          if (fifo_empty) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      head         <= '0;
      cycle_number <= '0;
      last_cycle   <= '0;
      inject_count <= '0;
      order_err    <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) head <= fifo_rd;
      if (enable) cycle_number <= cycle_number + 48'd1;
      if (push) last_cycle <= sched_cycle;
      if (accept && bad_entry) order_err <= 1'b1;
      if (fire && (inject_count != '1)) inject_count <= inject_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_verinject_injection_scheduler.sv
// Randomised and directed bench for the injection scheduler, checked each cycle against a queue model.
module tb_verinject_injection_scheduler;
  import verinject_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              sched_valid = 1'b0;
  logic              sched_ready;
  logic [47:0]       sched_cycle = '0;
  logic [31:0]       sched_bit = '0;
  logic [47:0]       cycle_number;
  logic [31:0]       injector_state;
  logic [CNT_W-1:0]  inject_count;
  logic              late_pulse;
  logic              order_err;
  logic              busy;

  int compared   = 0;
  int mismatched = 0;

  verinject_injection_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .enable                    (enable),
    .sched_valid               (sched_valid),
    .sched_ready               (sched_ready),
    .sched_cycle               (sched_cycle),
    .sched_bit                 (sched_bit),
    .cycle_number              (cycle_number),
    .verinject__injector_state (injector_state),
    .inject_count              (inject_count),
    .late_pulse                (late_pulse),
    .order_err                 (order_err),
    .busy                      (busy)
  );

  always #5 clock = ~clock;

  // Reference model: pending entries waiting in a queue, one armed entry, a counter.
  logic [47:0]       m_cyc;
  logic [47:0]       m_last;
  inj_entry_t        m_q[$];
  logic              m_hv;
  inj_entry_t        m_head;
  logic [CNT_W-1:0]  m_cnt;
  logic              m_oerr;
  logic [47:0]       log_c[$];
  logic [31:0]       log_b[$];
  logic              log_l[$];

  function automatic logic m_fire();
    return m_hv && enable && (m_head.cycle <= m_cyc);
  endfunction

  initial begin : model
    logic       f;
    logic       do_push;
    inj_entry_t ne;
    m_cyc = '0; m_last = '0; m_hv = 1'b0; m_head = '0; m_cnt = '0; m_oerr = 1'b0;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_cyc = '0; m_last = '0; m_hv = 1'b0; m_cnt = '0; m_oerr = 1'b0;
        m_q.delete();
      end else begin
        f = m_fire();
        if (f) begin
          log_c.push_back(m_cyc);
          log_b.push_back(m_head.bit_idx);
          log_l.push_back(m_head.cycle < m_cyc);
          if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end
        do_push = 1'b0;
        if (sched_valid && (m_q.size() < DEPTH)) begin
          if ((sched_cycle < m_last) || (sched_bit == INJ_IDLE)) begin
            m_oerr = 1'b1;
          end else begin
            do_push = 1'b1;
            ne.cycle = sched_cycle;
            ne.bit_idx = sched_bit;
            m_last = sched_cycle;
          end
        end
        if (f || !m_hv) begin
          if (m_q.size() > 0) begin
            m_head = m_q.pop_front();
            m_hv = 1'b1;
          end else begin
            m_hv = 1'b0;
          end
        end
        if (do_push) m_q.push_back(ne);
        if (enable) m_cyc = m_cyc + 48'd1;
      end
    end
  end

  initial begin : compare
    logic [31:0] e_inj;
    logic        e_late;
    logic        e_busy;
    logic        e_ready;
    forever begin
      @(negedge clock);
      e_inj   = m_fire() ? m_head.bit_idx : INJ_IDLE;
      e_late  = m_fire() && (m_head.cycle < m_cyc);
      e_busy  = m_hv || (m_q.size() != 0);
      e_ready = (m_q.size() < DEPTH);
      compared++;
      if (injector_state !== e_inj || late_pulse !== e_late || busy !== e_busy ||
          sched_ready !== e_ready || cycle_number !== m_cyc || inject_count !== m_cnt ||
          order_err !== m_oerr) begin
        mismatched++;
        $display("FAIL cycle_cmp t=%0t: got inj=%h late=%b busy=%b rdy=%b cyc=%0d cnt=%0d oerr=%b; want inj=%h late=%b busy=%b rdy=%b cyc=%0d cnt=%0d oerr=%b",
                 $time, injector_state, late_pulse, busy, sched_ready, cycle_number, inject_count, order_err,
                 e_inj, e_late, e_busy, e_ready, m_cyc, m_cnt, m_oerr);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_fire(input string name, input int idx, input logic [47:0] c,
                            input logic [31:0] b, input logic l);
    if (idx >= log_c.size()) begin
      compared++;
      mismatched++;
      $display("FAIL %s: fire #%0d missing, want cycle %0d bit %h", name, idx, c, b);
    end else begin
      check({name, "_cycle"}, 64'(log_c[idx]), 64'(c));
      check({name, "_bit"}, 64'(log_b[idx]), 64'(b));
      check({name, "_late"}, 64'(log_l[idx]), 64'(l));
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #3 reset = 1'b1;
    sched_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    enable = 1'b1;
    log_c.delete(); log_b.delete(); log_l.delete();
  endtask

  task automatic push(input logic [47:0] c, input logic [31:0] b);
    int n;
    sched_valid = 1'b1;
    sched_cycle = c;
    sched_bit = b;
    n = 0;
    forever begin
      @(negedge clock);
      if (sched_ready) break;
      n++;
      if (n > 5000) begin
        compared++;
        mismatched++;
        $display("FAIL push_timeout: ready stayed 0, want 1");
        break;
      end
    end
    @(posedge clock);
    #1 sched_valid = 1'b0;
    $display("push cycle=%0d bit=%h", c, b);
  endtask

  task automatic wait_cycle(input logic [47:0] target);
    int n;
    n = 0;
    while (cycle_number != target && n < 5000) begin
      @(posedge clock);
      #1 n++;
    end
    if (n >= 5000) begin
      compared++;
      mismatched++;
      $display("FAIL wait_timeout: cycle_number=%0d, want %0d", cycle_number, target);
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_inj", 64'(injector_state), 64'(INJ_IDLE));
    check("rst_cyc", 64'(cycle_number), 64'd0);
    check("rst_ready", 64'(sched_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);

    // Single entry on time
    push(48'd10, 32'd5);
    wait_cycle(48'd15);
    check("s1_n", 64'(log_c.size()), 64'd1);
    check_fire("s1_f0", 0, 48'd10, 32'd5, 1'b0);
    check("s1_count", 64'(inject_count), 64'd1);

    // Shared target cycle: later entries slip and are late
    do_reset();
    push(48'd20, 32'd3);
    push(48'd20, 32'd7);
    push(48'd21, 32'd9);
    wait_cycle(48'd25);
    check("s2_n", 64'(log_c.size()), 64'd3);
    check_fire("s2_f0", 0, 48'd20, 32'd3, 1'b0);
    check_fire("s2_f1", 1, 48'd21, 32'd7, 1'b1);
    check_fire("s2_f2", 2, 48'd22, 32'd9, 1'b1);
    check("s2_count", 64'(inject_count), 64'd3);

    // Out-of-order entry dropped
    do_reset();
    push(48'd30, 32'd1);
    push(48'd25, 32'd2);
    wait_cycle(48'd35);
    check("s3_n", 64'(log_c.size()), 64'd1);
    check_fire("s3_f0", 0, 48'd30, 32'd1, 1'b0);
    check("s3_oerr", 64'(order_err), 64'd1);

    // Fill head plus FIFO, all targeting cycle 1000
    do_reset();
    for (int i = 0; i <= DEPTH; i++) push(48'd1000, 32'(i));
    @(negedge clock);
    check("s4_full_ready", 64'(sched_ready), 64'd0);
    wait_cycle(48'd1000);
    check("s4_ready_at_fire", 64'(sched_ready), 64'd0);
    @(posedge clock);
    #1 check("s4_ready_after", 64'(sched_ready), 64'd1);
    wait_cycle(48'd1012);
    check("s4_n", 64'(log_c.size()), 64'(DEPTH + 1));
    for (int i = 0; i <= DEPTH; i++)
      check_fire($sformatf("s4_f%0d", i), i, 48'(1000 + i), 32'(i), (i > 0));

    // Injector reset command with the counter frozen across its target
    do_reset();
    push(48'd40, INJ_RESET);
    wait_cycle(48'd38);
    enable = 1'b0;
    repeat (8) @(posedge clock);
    #1 check("s5_frozen", 64'(cycle_number), 64'd38);
    check("s5_nofire", 64'(log_c.size()), 64'd0);
    enable = 1'b1;
    wait_cycle(48'd45);
    check("s5_n", 64'(log_c.size()), 64'd1);
    check_fire("s5_f0", 0, 48'd40, INJ_RESET, 1'b0);

    // Asynchronous reset while firing
    do_reset();
    push(48'd15, 32'd4);
    push(48'd50, 32'd6);
    wait_cycle(48'd15);
    check("s6_firing", 64'(injector_state), 64'd4);
    #3 reset = 1'b1;
    #1 check("s6_inj", 64'(injector_state), 64'(INJ_IDLE));
    check("s6_cyc", 64'(cycle_number), 64'd0);
    check("s6_busy", 64'(busy), 64'd0);
    check("s6_ready", 64'(sched_ready), 64'd1);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (60) @(posedge clock);
    #1 check("s6_discarded", 64'(inject_count), 64'd0);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      sched_valid = ($urandom_range(0, 2) != 0);
      enable = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 9))
        0:       sched_cycle = (m_last > 0) ? m_last - 48'd1 : m_last;
        1:       sched_cycle = m_cyc + 48'($urandom_range(0, 40));
        default: sched_cycle = m_last + 48'($urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 9))
        0:       sched_bit = INJ_IDLE;
        1:       sched_bit = INJ_RESET;
        default: sched_bit = $urandom;
      endcase
      @(posedge clock);
      #1;
    end
    sched_valid = 1'b0;
    enable = 1'b1;
    repeat (200) @(posedge clock);
    #1 $display("random phase: fires=%0d order_err=%b", log_c.size(), order_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
